// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM states shared by the multi-cycle ALU.
package alu_pkg;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_NAND = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SHL  = 3'b011;
  localparam logic [2:0] ALU_SRA  = 3'b100;
  localparam logic [2:0] ALU_EQ   = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: bit-serial shifts and shift-add multiply; done flags the final step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cy
);
  localparam int CW = SHAMT_W + 1;
  logic [WIDTH-1:0] sh, sh_n;
  logic [2*WIDTH-1:0] mcand, acc, acc_n;
  logic [CW-1:0] cnt;
  logic is_mul, is_sra;
  // sh holds the shift operand, or the multiplier being consumed LSB first
  always_comb begin
    acc_n = acc + (sh[0] ? mcand : '0);
    sh_n = is_mul ? sh >> 1 : is_sra ? {sh[WIDTH-1], sh[WIDTH-1:1]} : sh << 1;
    res = is_mul ? acc_n[WIDTH-1:0] : sh_n;
    cy = is_mul ? |acc_n[2*WIDTH-1:WIDTH] : is_sra ? sh[0] : sh[WIDTH-1];
    done = cnt == CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      mcand <= '0;
      acc <= '0;
      cnt <= '0;
      is_mul <= 1'b0;
      is_sra <= 1'b0;
    end else if (load) begin
      sh <= op == ALU_MUL ? b : a;
      mcand <= {{WIDTH{1'b0}}, a};
      acc <= '0;
      cnt <= op == ALU_MUL ? CW'(WIDTH) : CW'(b[SHAMT_W-1:0]);
      is_mul <= op == ALU_MUL;
      is_sra <= op == ALU_SRA;
    end else if (step) begin
      sh <= sh_n;
      mcand <= mcand << 1;
      acc <= acc_n;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU; single-cycle ops resolve at accept, shifts/multiply iterate.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy
);
  state_t state, state_n;
  logic accept, iter_op, step, lt, it_done, it_cy, sc_cy, sc_zero;
  logic [WIDTH-1:0] it_res, sc_res;
  logic [WIDTH:0] sum, diff;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign busy = state == EXEC;
  // zero shift amounts skip EXEC and pass data1 through as a single-cycle op
  always_comb begin
    accept = in_valid && in_ready;
    iter_op = alu_op == ALU_MUL || ((alu_op == ALU_SHL || alu_op == ALU_SRA) && data2[SHAMT_W-1:0] != '0);
    step = state == EXEC;
    sum = {1'b0, data1} + {1'b0, data2};
    diff = {1'b0, data1} - {1'b0, data2};
    lt = $signed(data1) < $signed(data2);
    sc_res = alu_op == ALU_ADD ? sum[WIDTH-1:0] :
             alu_op == ALU_NAND ? ~(data1 & data2) :
             alu_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} :
             alu_op == ALU_SUB ? diff[WIDTH-1:0] :
             alu_op == ALU_EQ ? '0 : data1;
    sc_cy = alu_op == ALU_ADD ? sum[WIDTH] : alu_op == ALU_SUB ? diff[WIDTH] : 1'b0;
    sc_zero = alu_op == ALU_EQ ? data1 == data2 : sc_res == '0;
    state_n = state == EXEC ? (it_done ? DONE : EXEC) :
              accept ? (iter_op ? EXEC : DONE) :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
    end else if (accept && !iter_op) begin
      result <= sc_res;
      zero <= sc_zero;
      carry <= sc_cy;
    end else if (step && it_done) begin
      result <= it_res;
      zero <= it_res == '0;
      carry <= it_cy;
    end
  alu_iter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept && iter_op),
    .step(step),
    .op(alu_op),
    .a(data1),
    .b(data2),
    .done(it_done),
    .res(it_res),
    .cy(it_cy)
  );
endmodule
